fp_result_packer: RTL and testbench
===================================

// Module: fp_result_packer
// PURPOSE
//  Output end of the FPU datapath: accepts arithmetic results in internal FloPoCo format
//  ({exc[1:0],sign,exp,frac}; exc 00=zero 01=normal 10=inf 11=NaN) with per-op flags
//  {NV,OF,UF,NX} from the add/sub unit, converts them to IEEE-754 binary64/binary32
//  (binary32 NaN-boxed), and hands them to writeback over valid/ready.
//  Also accumulates a sticky FFLAGS register for the CSR file.
// PARAMETERS
//  TAG_W   5   width of destination-register tag carried alongside each result
//  CNT_W   16  width of retired-result counter (wraps)
// PORTS
//  CLK         in   1       clock, all state on rising edge
//  RST         in   1       synchronous, active-high reset
//  IN_VALID    in   1       result valid from arithmetic unit
//  IN_READY    out  1       packer can accept this cycle
//  IN_DATA     in   66      FloPoCo result; SP in [33:0], [65:34] ignored when SP
//  IN_SP_DP    in   1       1=SP (8/23), 0=DP (11/52)
//  IN_FLAGS    in   4       {NV,OF,UF,NX} for this result
//  IN_TAG      in   TAG_W   destination tag
//  OUT_VALID   out  1       packed result valid
//  OUT_READY   in   1       writeback accepts
//  OUT_DATA    out  64      IEEE result; SP = {32'hFFFF_FFFF, sp32}
//  OUT_FLAGS   out  4       final {NV,OF,UF,NX} (input flags OR packer-raised flags)
//  OUT_TAG     out  TAG_W   tag of OUT_DATA
//  FFLAGS      out  4       sticky OR of OUT_FLAGS of every retired result
//  FFLAGS_CLR  in   1       clear sticky flags
//  RETIRE_CNT  out  CNT_W   count of results handed off (OUT_VALID & OUT_READY)
// BEHAVIOUR
//  Reset: OUT_VALID=0, OUT_DATA=0, OUT_FLAGS=0, OUT_TAG=0, FFLAGS=0, RETIRE_CNT=0,
//   both stage valids 0; IN_READY=1 in the first cycle after RST deasserts.
//  Pipeline: S1 = register input + classify; S2 = packed output register. Latency 2 cycles
//   IN fire -> OUT_VALID; full throughput (1/cycle) while OUT_READY=1.
//  Handshake: adv2 = !S2.v | OUT_READY; adv1 = !S1.v | adv2; IN_READY = adv1 (combinational,
//   no path from IN_VALID). OUT_DATA/FLAGS/TAG stable while OUT_VALID & !OUT_READY.
//   No result dropped or duplicated under any stall pattern.
//  Conversion (exponent bias identical in both formats, fields copied verbatim):
//   exc 00 -> {sign, 0, 0} (signed zero)
//   exc 01, exp!=0 -> {sign, exp, frac}
//   exc 01, exp==0 -> {sign, 0, 0} (no subnormal encode), raise UF and NX
//   exc 01, exp==all-ones -> {sign, inf}, raise OF and NX
//   exc 10 -> {sign, exp all-ones, frac 0}
//   exc 11 -> canonical qNaN DP 64'h7FF8_0000_0000_0000, SP 32'h7FC0_0000, sign dropped
//  FFLAGS: on cycle with OUT_VALID&OUT_READY, FFLAGS <= (FFLAGS_CLR ? 0 : FFLAGS) | OUT_FLAGS;
//   else FFLAGS <= FFLAGS_CLR ? 0 : FFLAGS. Clear loses to same-cycle retire.
//  RETIRE_CNT increments on each handoff, wraps 2^CNT_W-1 -> 0.
//  RST mid-operation: in-flight results discarded, no FFLAGS update that cycle.
// TESTING
//  DP in 66'h1_3FF0_0000_0000_0000 (1.0), flags 0 -> 2 cycles later OUT_DATA 64'h3FF0_0000_0000_0000
//  SP exc=11, sign=1 -> OUT_DATA 64'hFFFF_FFFF_7FC0_0000; exc=01, exp=0 -> +0, OUT_FLAGS=4'b0011
//  Stream 8 results, OUT_READY toggled 1-0-0-1 -> all 8 out in order, tags 0..7, no loss
//  Retire OF result with FFLAGS_CLR=1 same cycle, FFLAGS was 4'b0001 -> FFLAGS=4'b0100
//  CNT_W=4, 17 handoffs -> RETIRE_CNT=1; RST with S1,S2 full -> OUT_VALID=0 next cycle

Source files
------------

// File: rtl/fp_result_packer_if.sv
// Handshake and status bundle between the FPU result packer and its neighbours.
// The master side is the arithmetic unit plus writeback; the slave side is the packer.
interface fp_result_packer_if #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [65:0]      in_data;
  logic             in_sp_dp;
  logic [3:0]       in_flags;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  logic [3:0]       fflags;
  logic             fflags_clr;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output in_valid, in_data, in_sp_dp, in_flags, in_tag, out_ready, fflags_clr,
    input  in_ready, out_valid, out_data, out_flags, out_tag, fflags, retire_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sp_dp, in_flags, in_tag, out_ready, fflags_clr,
    output in_ready, out_valid, out_data, out_flags, out_tag, fflags, retire_cnt
  );
endinterface

// File: rtl/fp_result_packer.sv
// Converts FloPoCo-format FPU results to IEEE binary64/binary32 (NaN-boxed) in a
// two-stage valid/ready pipeline, and keeps sticky FFLAGS and a retired-result count.
module fp_result_packer #(
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  fp_result_packer_if.slave io_bus
);

  typedef enum logic [2:0] {
    C_ZERO, C_NORM, C_UFLOW, C_OFLOW, C_INF, C_NAN
  } class_e;

  logic             w_adv1, w_adv2, w_fire_out;
  logic [1:0]       w_exc;
  logic             w_sign;
  logic [10:0]      w_exp;
  logic [51:0]      w_frac;
  logic             w_exp_max;
  class_e           w_class;

  logic             r_s1_v;
  class_e           r_s1_class;
  logic             r_s1_sp;
  logic             r_s1_sign;
  logic [10:0]      r_s1_exp;
  logic [51:0]      r_s1_frac;
  logic [3:0]       r_s1_flags;
  logic [TAG_W-1:0] r_s1_tag;

  logic [31:0]      w_sp32;
  logic [63:0]      w_dp64;
  logic [63:0]      w_pack_data;
  logic [3:0]       w_pack_flags;

  logic             r_s2_v;
  logic [63:0]      r_s2_data;
  logic [3:0]       r_s2_flags;
  logic [TAG_W-1:0] r_s2_tag;
  logic [3:0]       r_fflags;
  logic [CNT_W-1:0] r_cnt;

  assign w_adv2     = !r_s2_v || io_bus.out_ready;
  assign w_adv1     = !r_s1_v || w_adv2;
  assign w_fire_out = r_s2_v && io_bus.out_ready;

  // Field extraction and classification of the incoming result.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_exc     = io_bus.in_sp_dp ? io_bus.in_data[33:32] : io_bus.in_data[65:64];
    w_sign    = io_bus.in_sp_dp ? io_bus.in_data[31]    : io_bus.in_data[63];
    w_exp     = io_bus.in_sp_dp ? {3'b000, io_bus.in_data[30:23]} : io_bus.in_data[62:52];
    w_frac    = io_bus.in_sp_dp ? {29'd0, io_bus.in_data[22:0]}   : io_bus.in_data[51:0];
    w_exp_max = io_bus.in_sp_dp ? (io_bus.in_data[30:23] == 8'hFF)
                                : (io_bus.in_data[62:52] == 11'h7FF);
    w_class   = C_NAN;
    unique case (w_exc)
      2'b00: w_class = C_ZERO;
      2'b01: begin
        if (w_exp == 11'd0)  w_class = C_UFLOW;
        else if (w_exp_max)  w_class = C_OFLOW;
        else                 w_class = C_NORM;
      end
      2'b10: w_class = C_INF;
      2'b11: w_class = C_NAN;
    endcase
  end

  always_comb begin
    w_sp32       = {r_s1_sign, 31'd0};
    w_dp64       = {r_s1_sign, 63'd0};
    w_pack_flags = r_s1_flags;
    unique case (r_s1_class)
      C_ZERO: ;
      C_UFLOW: w_pack_flags = r_s1_flags | 4'b0011;
      C_NORM: begin
        w_sp32 = {r_s1_sign, r_s1_exp[7:0], r_s1_frac[22:0]};
        w_dp64 = {r_s1_sign, r_s1_exp, r_s1_frac};
      end
      C_OFLOW, C_INF: begin
        w_sp32 = {r_s1_sign, 8'hFF, 23'd0};
        w_dp64 = {r_s1_sign, 11'h7FF, 52'd0};
        if (r_s1_class == C_OFLOW) w_pack_flags = r_s1_flags | 4'b0101;
      end
      C_NAN: begin
        w_sp32 = 32'h7FC0_0000;
        w_dp64 = 64'h7FF8_0000_0000_0000;
      end
      default: ;
    endcase
    w_pack_data = r_s1_sp ? {32'hFFFF_FFFF, w_sp32} : w_dp64;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_v     <= 1'b0;
      r_s2_v     <= 1'b0;
      r_s2_data  <= '0;
      r_s2_flags <= '0;
      r_s2_tag   <= '0;
      r_fflags   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_adv1) r_s1_v <= io_bus.in_valid;
      if (w_adv2) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_s2_data  <= w_pack_data;
          r_s2_flags <= w_pack_flags;
          r_s2_tag   <= r_s1_tag;
        end
      end
      // A retire in the same cycle as a clear still leaves its own flags behind.
      if (w_fire_out) begin
        r_fflags <= (io_bus.fflags_clr ? 4'b0000 : r_fflags) | r_s2_flags;
        r_cnt    <= r_cnt + CNT_W'(1);
      end else if (io_bus.fflags_clr) begin
        r_fflags <= '0;
      end
    end
  end

  // NOTE: the S1 payload is qualified by r_s1_v, so it is deliberately left without a reset.
  always_ff @(posedge i_clk) begin
    if (w_adv1 && io_bus.in_valid) begin
      r_s1_class <= w_class;
      r_s1_sp    <= io_bus.in_sp_dp;
      r_s1_sign  <= w_sign;
      r_s1_exp   <= w_exp;
      r_s1_frac  <= w_frac;
      r_s1_flags <= io_bus.in_flags;
      r_s1_tag   <= io_bus.in_tag;
    end
  end

  assign io_bus.in_ready   = w_adv1;
  assign io_bus.out_valid  = r_s2_v;
  assign io_bus.out_data   = r_s2_data;
  assign io_bus.out_flags  = r_s2_flags;
  assign io_bus.out_tag    = r_s2_tag;
  assign io_bus.fflags     = r_fflags;
  assign io_bus.retire_cnt = r_cnt;

endmodule

// File: tb/tb_fp_result_packer.sv
// Self-checking bench for fp_result_packer: directed vector table, hand-written stall,
// flag-clear, wrap and reset sequences, and a randomized run against a scoreboard model.
`timescale 1ns/1ps
module tb_fp_result_packer;

  localparam int TAG_W = 5;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;

  fp_result_packer_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

  fp_result_packer #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      data;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic        sp;
    logic [65:0] data;
    logic [3:0]  flags;
    logic [63:0] exp_data;
    logic [3:0]  exp_flags;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  exp_t             q[$];
  logic [TAG_W-1:0] seen_tags[$];
  logic [3:0]       m_ff;
  logic [CNT_W-1:0] m_cnt;
  int               mode;
  int               ph;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: IEEE packing computed from field widths with plain shifts and masks.
  function automatic exp_t ref_pack(input logic sp, input logic [65:0] d,
                                    input logic [3:0] fl, input logic [TAG_W-1:0] tag);
    exp_t        e;
    int          fw, ew;
    logic [65:0] frac, expo, emax, sgn, exc, t;
    fw   = sp ? 23 : 52;
    ew   = sp ? 8 : 11;
    emax = (66'd1 << ew) - 66'd1;
    frac = d & ((66'd1 << fw) - 66'd1);
    expo = (d >> fw) & emax;
    sgn  = (d >> (fw + ew)) & 66'd1;
    exc  = (d >> (fw + ew + 1)) & 66'd3;
    e.flags = fl;
    e.tag   = tag;
    case (exc[1:0])
      2'd0: t = sgn << (fw + ew);
      2'd1: begin
        if (expo == 66'd0) begin
          t = sgn << (fw + ew);
          e.flags = fl | 4'b0011;
        end else if (expo == emax) begin
          t = (sgn << (fw + ew)) | (emax << fw);
          e.flags = fl | 4'b0101;
        end else begin
          t = (sgn << (fw + ew)) | (expo << fw) | frac;
        end
      end
      2'd2: t = (sgn << (fw + ew)) | (emax << fw);
      default: t = (emax << fw) | (66'd1 << (fw - 1));
    endcase
    e.data = sp ? {32'hFFFF_FFFF, t[31:0]} : t[63:0];
    return e;
  endfunction

  // Scoreboard and flag/counter model, sampled mid-cycle.
  always @(negedge clk) begin
    logic [3:0] nf;
    if (rst) begin
      q.delete();
      m_ff  = '0;
      m_cnt = '0;
    end else begin
      check("fflags_model", {60'd0, bus.fflags}, {60'd0, m_ff});
      check("retire_cnt_model", {60'd0, bus.retire_cnt}, {60'd0, m_cnt});
      nf = '0;
      if (bus.out_valid) begin
        check("out_has_pending", {63'd0, q.size() > 0}, 64'd1);
        if (q.size() > 0) begin
          check("out_data", bus.out_data, q[0].data);
          check("out_flags", {60'd0, bus.out_flags}, {60'd0, q[0].flags});
          check("out_tag", {59'd0, bus.out_tag}, {59'd0, q[0].tag});
          if (bus.out_ready) begin
            nf = q[0].flags;
            seen_tags.push_back(q[0].tag);
            void'(q.pop_front());
            m_cnt = m_cnt + 1'b1;
          end
        end
      end
      m_ff = (bus.fflags_clr ? 4'b0000 : m_ff) | nf;
      if (bus.in_valid && bus.in_ready)
        q.push_back(ref_pack(bus.in_sp_dp, bus.in_data, bus.in_flags, bus.in_tag));
    end
  end

  always @(posedge clk) begin
    #1;
    case (mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        bus.out_ready = (ph == 0) || (ph == 3);
        ph = (ph + 1) % 4;
      end
      default: ;
    endcase
  end

  // Caller must be positioned just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic sp, input logic [65:0] d, input logic [3:0] fl,
                      input logic [TAG_W-1:0] tag);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sp_dp = sp;
    bus.in_data  = d;
    bus.in_flags = fl;
    bus.in_tag   = tag;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) check("in_ready_timeout", {63'd0, ok}, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !bus.out_valid) break;
    end
    check(name, 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [65:0] rand_result(input logic sp);
    int          fw, ew;
    logic [65:0] e, d, emax;
    fw   = sp ? 23 : 52;
    ew   = sp ? 8 : 11;
    emax = (66'd1 << ew) - 66'd1;
    case ($urandom_range(0, 3))
      0: e = 66'd0;
      1: e = emax;
      default: e = {34'd0, $urandom} & emax;
    endcase
    d = (66'($urandom_range(0, 3)) << (fw + ew + 1)) | (66'($urandom_range(0, 1)) << (fw + ew)) |
        (e << fw) | ({2'b00, $urandom, $urandom} & ((66'd1 << fw) - 66'd1));
    if (sp) d = d | (66'($urandom) << 34);
    return d;
  endfunction

  vec_t vt[$];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic sp;
    vt.push_back('{1'b0, 66'h1_3FF0_0000_0000_0000, 4'b0000, 64'h3FF0_0000_0000_0000, 4'b0000});
    vt.push_back('{1'b1, {32'd0, 2'b11, 1'b1, 8'h12, 23'h5}, 4'b0000, 64'hFFFF_FFFF_7FC0_0000, 4'b0000});
    vt.push_back('{1'b1, {32'd0, 2'b01, 1'b0, 8'h00, 23'h7ABCD}, 4'b0000, 64'hFFFF_FFFF_0000_0000, 4'b0011});
    vt.push_back('{1'b0, {2'b01, 1'b1, 11'h7FF, 52'h123}, 4'b0001, 64'hFFF0_0000_0000_0000, 4'b0101});
    vt.push_back('{1'b0, {2'b00, 1'b1, 11'h400, 52'h5}, 4'b1000, 64'h8000_0000_0000_0000, 4'b1000});
    vt.push_back('{1'b0, {2'b10, 1'b0, 11'h123, 52'hABC}, 4'b0000, 64'h7FF0_0000_0000_0000, 4'b0000});
    vt.push_back('{1'b0, {2'b11, 1'b1, 11'h7FF, 52'h1}, 4'b1000, 64'h7FF8_0000_0000_0000, 4'b1000});
    vt.push_back('{1'b1, {32'hDEAD_BEEF, 2'b01, 1'b1, 8'h80, 23'h40_0001}, 4'b0001, 64'hFFFF_FFFF_C040_0001, 4'b0001});
    vt.push_back('{1'b1, {32'd0, 2'b10, 1'b1, 8'h05, 23'h1}, 4'b0000, 64'hFFFF_FFFF_FF80_0000, 4'b0000});
    vt.push_back('{1'b1, {32'd0, 2'b01, 1'b0, 8'hFF, 23'h3}, 4'b0000, 64'hFFFF_FFFF_7F80_0000, 4'b0101});
    vt.push_back('{1'b0, {2'b01, 1'b1, 11'h000, 52'hF}, 4'b0000, 64'h8000_0000_0000_0000, 4'b0011});

    mode = 0; ph = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sp_dp = 1'b0; bus.in_data = '0; bus.in_flags = '0;
    bus.in_tag = '0; bus.out_ready = 1'b1; bus.fflags_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_flags", {60'd0, bus.out_flags}, 64'd0);
    check("rst_out_tag", {59'd0, bus.out_tag}, 64'd0);
    check("rst_fflags", {60'd0, bus.fflags}, 64'd0);
    check("rst_retire_cnt", {60'd0, bus.retire_cnt}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed conversion table, two-cycle latency
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      send(v.sp, v.data, v.flags, TAG_W'(i));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {63'd0, bus.out_valid}, 64'd1);
      check($sformatf("vec%0d_data", i), bus.out_data, v.exp_data);
      check($sformatf("vec%0d_flags", i), {60'd0, bus.out_flags}, {60'd0, v.exp_flags});
      check($sformatf("vec%0d_tag", i), {59'd0, bus.out_tag}, 64'(i));
      @(posedge clk); #1;
    end
    drain("table_drain");

    // Eight back-to-back results under a 1-0-0-1 ready pattern
    seen_tags.delete();
    ph = 0; mode = 2;
    for (int i = 0; i < 8; i++) send(1'b0, 66'h1_4000_0000_0000_0000 + 66'(i), 4'b0000, TAG_W'(i));
    drain("stream_drain");
    mode = 0;
    check("stream_count", 64'(seen_tags.size()), 64'd8);
    for (int i = 0; i < 8 && i < seen_tags.size(); i++)
      check($sformatf("stream_tag%0d", i), {59'd0, seen_tags[i]}, 64'(i));

    // Sticky flag clear racing a retire
    mode = 3; bus.out_ready = 1'b1;
    bus.fflags_clr = 1'b1;
    @(posedge clk); #1 bus.fflags_clr = 1'b0;
    @(negedge clk);
    check("fflags_cleared", {60'd0, bus.fflags}, 64'd0);
    @(posedge clk); #1;
    send(1'b0, 66'h1_3FF8_0000_0000_0000, 4'b0001, 5'd9);
    drain("nx_drain");
    check("fflags_nx", {60'd0, bus.fflags}, 64'b0001);
    bus.out_ready = 1'b0;
    send(1'b0, 66'h1_4010_0000_0000_0000, 4'b0100, 5'd10);
    @(posedge clk); #1;
    bus.fflags_clr = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.fflags_clr = 1'b0;
    @(negedge clk);
    check("fflags_clr_vs_retire", {60'd0, bus.fflags}, 64'b0100);
    @(posedge clk); #1;

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(1'b0, 66'h1_3FF0_0000_0000_0001, 4'b0000, 5'd1);
    send(1'b0, 66'h1_3FF0_0000_0000_0002, 4'b0000, 5'd2);
    @(negedge clk);
    check("full_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("full_out_valid", {63'd0, bus.out_valid}, 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("midrst_fflags", {60'd0, bus.fflags}, 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_ghost", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;

    // Counter wrap: 17 handoffs on a 4-bit counter
    mode = 0;
    for (int i = 0; i < 17; i++) send(1'b1, {32'd0, 2'b01, 1'b0, 8'h7F, 23'(i)}, 4'b0000, TAG_W'(i));
    drain("wrap_drain");
    check("retire_cnt_wrap", {60'd0, bus.retire_cnt}, 64'd1);

    // Randomized traffic with random backpressure and occasional clears
    mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      sp = 1'($urandom_range(0, 1));
      bus.fflags_clr = ($urandom_range(0, 15) == 0);
      send(sp, rand_result(sp), 4'($urandom), TAG_W'($urandom));
      bus.fflags_clr = 1'b0;
    end
    mode = 0;
    drain("random_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
